// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the 16-bit five-stage pipeline:
//                datapath/field widths, the default bubble instruction, the
//                fetch FSM state type and a sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int PC_W  = 16;   // program counter / instruction width
    localparam int OFF_W = 9;    // J-type jump offset field
    localparam int IMM_W = 6;    // branch immediate field (signed)

    localparam logic [PC_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Sign-extend the branch immediate to the PC width.
    function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Carries a valid bit, the fetched
//                instruction and its PC. Bubble has priority over load; with
//                neither asserted the register holds.
//  Ports       : CLK, RST_n (sync active-low), i_load, i_bubble,
//                i_instr/i_pc (data in), o_valid/o_instr/o_pc (register out)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [PC_W-1:0] i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    output logic [PC_W-1:0] o_instr,
    output logic [PC_W-1:0] o_pc
);

    logic            r_valid;
    logic [PC_W-1:0] r_instr;
    logic [PC_W-1:0] r_pc;

    always_ff @(posedge CLK) begin
        if (!RST_n || i_bubble) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns PC and return register RR,
//                selects the next PC (sequential / jump / branch / return /
//                loop), applies hazard stalls and squashes the wrong-path
//                instruction with a single bubble on a redirect.
//  Ports       : CLK, RST_n (sync active-low)
//                imem_addr/imem_data  - external combinational instruction memory
//                stall                - hazard hold
//                jmp_valid/jmp_offset, call_valid, br_taken/br_imm,
//                ret_valid, loop_valid/loop_target - redirect requests from ID
//                if_id_valid/if_id_instr/if_id_pc  - IF/ID register
//                rr                   - return register
//                redirect             - redirect accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [PC_W-1:0]   imem_data,
    input  logic              stall,
    input  logic              jmp_valid,
    input  logic [OFF_W-1:0]  jmp_offset,
    input  logic              call_valid,
    input  logic              br_taken,
    input  logic [IMM_W-1:0]  br_imm,
    input  logic              ret_valid,
    input  logic              loop_valid,
    input  logic [PC_W-1:0]   loop_target,
    output logic              if_id_valid,
    output logic [PC_W-1:0]   if_id_instr,
    output logic [PC_W-1:0]   if_id_pc,
    output logic [PC_W-1:0]   rr,
    output logic              redirect
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_rr;

    logic            w_redirect;
    logic            w_call_take;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_pc_en;
    logic            w_ifid_load;
    logic            w_ifid_bubble;

    // ------------------------------------------------------------------
    // Redirect qualification and target selection. Requests from decode
    // only mean something when ID holds a real instruction.
    // ------------------------------------------------------------------
    assign w_redirect = !stall && if_id_valid &&
                        (loop_valid || ret_valid || br_taken || jmp_valid);

    // A call only commits when the jump is the winning redirect source.
    assign w_call_take = w_redirect && call_valid && jmp_valid &&
                         !loop_valid && !ret_valid && !br_taken;

    always_comb begin
        w_target = {if_id_pc[PC_W-1:OFF_W], jmp_offset};
        if (loop_valid) begin
            w_target = loop_target;
        end else if (ret_valid) begin
            w_target = r_rr;
        end else if (br_taken) begin
            w_target = if_id_pc + sext_imm(br_imm);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Stall freezes the state, including FLUSH.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!stall) begin
            case (r_state)
                ST_BOOT:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = w_redirect ? ST_FLUSH : ST_RUN;
                // IF/ID is a bubble here, so no redirect can be accepted.
                ST_FLUSH: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (PC / IF/ID control)
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_en       = 1'b0;
        w_pc_nxt      = r_pc + 16'd1;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        if (!stall) begin
            case (r_state)
                ST_BOOT, ST_FLUSH: begin
                    w_pc_en     = 1'b1;
                    w_ifid_load = 1'b1;
                end
                ST_RUN: begin
                    w_pc_en = 1'b1;
                    if (w_redirect) begin
                        w_pc_nxt      = w_target;
                        w_ifid_bubble = 1'b1;
                    end else begin
                        w_ifid_load   = 1'b1;
                    end
                end
                default: begin
                    w_pc_en = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC and return register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_pc <= RESET_PC;
            r_rr <= '0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_pc_nxt;
            end
            if (w_call_take) begin
                r_rr <= if_id_pc + 16'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .i_load   (w_ifid_load),
        .i_bubble (w_ifid_bubble),
        .i_instr  (imem_data),
        .i_pc     (r_pc),
        .o_valid  (if_id_valid),
        .o_instr  (if_id_instr),
        .o_pc     (if_id_pc)
    );

    assign imem_addr = r_pc;
    assign rr        = r_rr;
    assign redirect  = w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Keeps an abstract model
//                of PC, RR and the IF/ID contents, compares every cycle, and
//                adds hand-computed literal checks for the directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        jmp_valid;
    logic [8:0]  jmp_offset;
    logic        call_valid;
    logic        br_taken;
    logic [5:0]  br_imm;
    logic        ret_valid;
    logic        loop_valid;
    logic [15:0] loop_target;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] rr;
    logic        redirect;

    always #5 CLK = ~CLK;

    // Instruction memory contents: word i holds 16'h1000 + i.
    assign imem_data = imem_addr + 16'h1000;

    fetch_unit dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .jmp_valid   (jmp_valid),
        .jmp_offset  (jmp_offset),
        .call_valid  (call_valid),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .ret_valid   (ret_valid),
        .loop_valid  (loop_valid),
        .loop_target (loop_target),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .rr          (rr),
        .redirect    (redirect)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Abstract model state
    logic [15:0] m_pc, m_rr, m_instr, m_ipc;
    logic        m_v;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at the negative edge, advance the model by the
    // architectural rules, then release after the rising edge.
    task automatic cyc();
        logic        exp_redir;
        logic [15:0] tgt;
        @(negedge CLK);
        exp_redir = !stall && m_v && (loop_valid || ret_valid || br_taken || jmp_valid);
        chk("imem_addr",   imem_addr,          m_pc);
        chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_v});
        chk("if_id_instr", if_id_instr,        m_instr);
        chk("if_id_pc",    if_id_pc,           m_ipc);
        chk("rr",          rr,                 m_rr);
        chk("redirect",    {15'd0, redirect},  {15'd0, exp_redir});
        if (!RST_n) begin
            m_pc = 16'h0000; m_rr = 16'h0000;
            m_v = 1'b0; m_instr = 16'h0000; m_ipc = 16'h0000;
        end else if (stall) begin
            // everything holds
        end else if (exp_redir) begin
            if (loop_valid)      tgt = loop_target;
            else if (ret_valid)  tgt = m_rr;
            else if (br_taken)   tgt = m_ipc + 16'($signed(br_imm));
            else begin
                tgt = (m_ipc & 16'hFE00) | 16'(jmp_offset);
                if (call_valid) m_rr = m_ipc + 16'd1;
            end
            m_pc = tgt;
            m_v = 1'b0; m_instr = 16'h0000; m_ipc = 16'h0000;
        end else begin
            m_v = 1'b1; m_instr = mem(m_pc); m_ipc = m_pc;
            m_pc = m_pc + 16'd1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        stall = 0; jmp_valid = 0; call_valid = 0; br_taken = 0;
        ret_valid = 0; loop_valid = 0;
        jmp_offset = '0; br_imm = '0; loop_target = '0;
    endtask

    // Steer IF/ID to hold the instruction at address t via a loop redirect.
    task automatic goto_pc(input logic [15:0] t);
        idle();
        for (int k = 0; k < 4 && !m_v; k++) cyc();
        chk("goto_ready", {15'd0, if_id_valid}, 16'd1);
        loop_valid = 1; loop_target = t;
        cyc();
        idle();
        cyc();
        chk("goto_pc", if_id_pc, t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a_hold;
        idle();
        RST_n = 0;
        m_pc = 16'h0; m_rr = 16'h0; m_v = 0; m_instr = 16'h0; m_ipc = 16'h0;
        @(posedge CLK); #1;
        cyc();
        RST_n = 1;

        // Reset state, BOOT then sequential fetch
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_addr",  imem_addr,  16'h0000);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_rr",    rr,          16'h0000);
        cyc();
        chk("seq0_pc", if_id_pc, 16'h0000); chk("seq0_instr", if_id_instr, 16'h1000);
        chk("seq0_addr", imem_addr, 16'h0001);
        cyc();
        chk("seq1_instr", if_id_instr, 16'h1001); chk("seq1_addr", imem_addr, 16'h0002);
        cyc();
        chk("seq2_instr", if_id_instr, 16'h1002); chk("seq2_addr", imem_addr, 16'h0003);
        cyc();
        chk("seq3_addr", imem_addr, 16'h0004);

        // Jump from 0x0203 with offset 0x015
        goto_pc(16'h0203);
        jmp_valid = 1; jmp_offset = 9'h015;
        #1 chk("jmp_redirect", {15'd0, redirect}, 16'd1);
        cyc();
        chk("jmp_addr", imem_addr, 16'h0215);
        chk("jmp_bubble", {15'd0, if_id_valid}, 16'd0);
        idle();
        cyc();
        chk("jmp_land_pc", if_id_pc, 16'h0215);
        chk("jmp_land_instr", if_id_instr, 16'h1215);

        // Loop outranks branch; then branch alone
        goto_pc(16'h0010);
        loop_valid = 1; loop_target = 16'h0040; br_taken = 1; br_imm = 6'h3E;
        cyc();
        chk("loop_prio_addr", imem_addr, 16'h0040);
        goto_pc(16'h0010);
        br_taken = 1; br_imm = 6'h3E;
        cyc();
        chk("br_addr", imem_addr, 16'h000E);

        // Call then return
        goto_pc(16'h0050);
        jmp_valid = 1; call_valid = 1; jmp_offset = 9'h0A0;
        cyc();
        chk("call_rr", rr, 16'h0051);
        chk("call_addr", imem_addr, 16'h00A0);
        idle();
        cyc();
        ret_valid = 1;
        cyc();
        chk("ret_addr", imem_addr, 16'h0051);
        chk("ret_bubble", {15'd0, if_id_valid}, 16'd0);
        idle();
        cyc();
        chk("ret_land", if_id_pc, 16'h0051);

        // Stall freezes everything while a jump is presented
        goto_pc(16'h0100);
        a_hold = imem_addr;
        jmp_valid = 1; jmp_offset = 9'h033; stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_noredir", {15'd0, redirect}, 16'd0);
            cyc();
            chk("stall_addr", imem_addr, a_hold);
            chk("stall_ifpc", if_id_pc, 16'h0100);
            chk("stall_rr", rr, 16'h0051);
        end
        stall = 0;
        #1 chk("unstall_redir", {15'd0, redirect}, 16'd1);
        cyc();
        chk("unstall_addr", imem_addr, 16'h0033);
        idle();
        cyc();
        cyc();
        chk("jmp_once", if_id_pc, 16'h0034);

        // PC wrap
        goto_pc(16'hFFFF);
        chk("wrap_addr", imem_addr, 16'h0000);
        cyc();
        chk("wrap_ifpc", if_id_pc, 16'h0000);

        // Reset during FLUSH
        loop_valid = 1; loop_target = 16'h0123;
        cyc();
        idle();
        RST_n = 0;
        cyc();
        RST_n = 1;
        chk("rstf_addr", imem_addr, 16'h0000);
        chk("rstf_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rstf_rr", rr, 16'h0000);
        cyc();
        chk("rstf_boot", if_id_instr, 16'h1000);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            RST_n       = ($urandom_range(0, 99) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            loop_valid  = ($urandom_range(0, 9) == 0);
            ret_valid   = ($urandom_range(0, 7) == 0);
            br_taken    = ($urandom_range(0, 5) == 0);
            jmp_valid   = ($urandom_range(0, 4) == 0);
            call_valid  = jmp_valid && ($urandom_range(0, 1) == 1);
            jmp_offset  = 9'($urandom);
            br_imm      = 6'($urandom);
            loop_target = 16'($urandom);
            cyc();
        end
        RST_n = 1;
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipeline; feeds the decode stage through an IF/ID register that carries a valid bit.
- Owns the PC, the return register RR and next-PC selection (sequential, jump, branch, return, loop).
- Applies hazard stalls and squashes the wrong-path instruction when decode redirects the PC.
- Instruction memory stays external: combinational, word-addressed read.

Parameters:
- NOP_INSTR, 16'h0000, instruction word injected into IF/ID for a bubble.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_n  in  1  synchronous active-low reset.
- imem_addr  out  16  instruction memory address; equals PC.
- imem_data  in  16  instruction word at imem_addr, same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- jmp_valid  in  1  decode: J-type jump in ID.
- jmp_offset  in  9  jump offset field of the ID instruction.
- call_valid  in  1  decode: call in ID; save the return address. A call always also asserts jmp_valid.
- br_taken  in  1  decode: branch in ID, condition true.
- br_imm  in  6  branch immediate; signed.
- ret_valid  in  1  decode: return in ID.
- loop_valid  in  1  decode: for-loop back-edge taken.
- loop_target  in  16  loop target, taken from register bus A.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  IF/ID instruction; NOP_INSTR when invalid.
- if_id_pc  out  16  PC of the IF/ID instruction.
- rr  out  16  return register.
- redirect  out  1  combinational: a redirect is accepted this cycle.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-low, RST_n.
- Reset (RST_n=0 at an edge):
  - PC=RESET_PC, rr=0.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
  - FSM enters BOOT.
  - Reset overrides stall and all redirects.
- FSM states: BOOT, RUN, FLUSH.
  - BOOT: IF/ID loads imem_data at PC, PC <= PC+1, go to RUN. The BOOT cycle itself presents if_id_valid=0.
  - RUN: normal fetch.
  - FLUSH: one cycle after a redirect. IF/ID already holds a bubble; fetch proceeds from the new PC; return to RUN.
- Redirect qualification: redirect inputs count only while if_id_valid=1. Any redirect input asserted while if_id_valid=0 is ignored.
- Redirect priority: loop_valid > ret_valid > br_taken > jmp_valid.
- Targets (all 16-bit, modulo 2^16):
  - jump: {if_id_pc[15:9], jmp_offset}.
  - branch: if_id_pc + sign-extended br_imm.
  - return: rr.
  - loop: loop_target.
- redirect = !stall && if_id_valid && (loop_valid|ret_valid|br_taken|jmp_valid).
- When redirect=1:
  - PC <= selected target.
  - IF/ID <= bubble (valid=0, NOP_INSTR, pc 0).
  - FSM -> FLUSH.
  - Penalty: exactly one bubble.
- Sequential fetch (no redirect, no stall): PC <= PC+1; IF/ID <= {1, imem_data, PC}. PC 16'hFFFF wraps to 0.
- stall=1:
  - PC, IF/ID, rr and FSM state hold.
  - All redirect inputs are ignored; decode re-presents them next cycle.
  - Stall in FLUSH holds FLUSH.
- call_valid with redirect=1 and call_valid being the highest-priority source's companion (jmp):
  - rr <= if_id_pc+1 on the same edge.
  - If loop, ret or br outranks the jump, the call is squashed and rr is unchanged.
- Return with ret_valid: uses the pre-edge rr, so a call followed immediately by a return goes to the new rr one cycle later, with no bypass needed.
- No outputs are combinational from imem_data except through IF/ID.

Decomposition:
- Shared package (cpu_pkg):
  - NOP_INSTR default.
  - FSM state enum.
  - opcode/field width constants: PC_W=16, OFF_W=9, IMM_W=6.
- Natural sub-module: if_id_reg, the IF/ID pipeline register with load, hold and bubble controls and sync active-low reset.
- FSM and next-PC mux stay in fetch_unit.

Test Plan:
- Reset then 4 free cycles, imem[i]=16'h1000+i:
  - if_id sequence is invalid (BOOT), then (0,16'h1000), (1,16'h1001), (2,16'h1002).
  - imem_addr steps 1,2,3,4.
- jmp_valid with if_id_pc=16'h0203, offset=9'h015:
  - redirect=1; next PC=16'h0215.
  - IF/ID bubble one cycle; then instruction at 16'h0215 valid.
- Simultaneous loop_valid (target 16'h0040) and br_taken (imm 6'h3E, pc 16'h0010):
  - PC=16'h0040; branch ignored.
  - Then br alone at pc 16'h0010: target 16'h000E.
- call_valid+jmp_valid at if_id_pc=16'h0050:
  - rr=16'h0051.
  - Later ret_valid: PC=16'h0051 with one bubble.
- stall=1 for 3 cycles while jmp_valid=1:
  - PC, IF/ID and rr frozen; no redirect.
  - After stall drops, the jump is taken once.
- PC at 16'hFFFF, no redirect: PC wraps to 16'h0000. Separately, RST_n=0 mid-FLUSH: PC=0, FSM in BOOT, if_id_valid=0 next cycle.
